// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz display timing generator.
//
// A clock divider produces a one-clk pixel-tick enable (p_tick). The
// horizontal and vertical counters advance on that tick. hsync, vsync and
// video_on are registered from the next-state counter values, so they change
// on the same clk edge as pix_x/pix_y.
//
// Ports:
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-high reset; has priority over en
//   en         in   run enable; low freezes divider and counters
//   p_tick     out  one-clk pulse per pixel period (combinational)
//   pix_x      out  horizontal count, 0..H_TOTAL-1
//   pix_y      out  vertical count, 0..V_TOTAL-1
//   hsync      out  horizontal sync, active-low
//   vsync      out  vertical sync, active-low
//   video_on   out  high inside the visible area
//   frame_end  out  one-clk pulse on the last pixel tick of a frame
//
// CLK_DIV must be >= 2. Both totals must not exceed 1024 (10-bit counters).
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Sync decode helpers: true while the coordinate lies inside the pulse.
  function automatic logic in_hsync(input logic [9:0] x);
    return (x >= HS_FIRST) && (x <= HS_LAST);
  endfunction

  function automatic logic in_vsync(input logic [9:0] y);
    return (y >= VS_FIRST) && (y <= VS_LAST);
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             tick;

  // Next-state: divider, counters, then syncs decoded from the next counters
  always_comb begin
    tick       = en && (div_q == DIV_LAST);
    div_d      = div_q;
    x_d        = x_q;
    y_d        = y_q;
    hsync_d    = 1'b1;
    vsync_d    = 1'b1;
    video_on_d = 1'b0;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // While disabled the outputs idle (syncs inactive, blanked).
    if (en) begin
      hsync_d    = !in_hsync(x_d);
      vsync_d    = !in_vsync(y_d);
      video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
    end
  end

  // Register stage: counters and decoded outputs share one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign p_tick    = tick;
  assign frame_end = tick && (x_q == H_LAST) && (y_q == V_LAST);
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator that sources the pixel coordinate and blanking interface consumed by the on-screen text/symbol renderers (pix_x, pix_y, video_on).
- Drives the monitor's hsync/vsync pins.
- Produces 640x480@60 Hz timing from a 100 MHz system clock, using a pixel-tick enable rather than a derived clock.
- Sits at the top of the display path; every renderer and the final RGB mux are fed from it.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=2)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync pulse width, pixels
- H_BACK, 48, horizontal back porch, pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BACK, 33, vertical back porch, lines

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- en  in  1  run enable; low freezes timing
- p_tick  out  1  one-clk pulse per pixel period
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high inside the visible area
- frame_end  out  1  one-clk pulse on the last pixel tick of a frame

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
- V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Both totals must be <= 1024; counters are 10 bits.
- Reset values: divider=0, pix_x=0, pix_y=0, p_tick=0, hsync=1, vsync=1, video_on=0, frame_end=0.
- Divider: counts 0..CLK_DIV-1 while en=1, then wraps.
- p_tick=1 exactly in the clk where the divider equals CLK_DIV-1; the first tick after reset occurs in the CLK_DIV-th clk.
- pix_x increments on each p_tick. At H_TOTAL-1 it wraps to 0, and on that same tick pix_y increments.
- pix_y wraps to 0 at V_TOTAL-1 when pix_x also wraps.
- hsync, vsync and video_on are registered, decoded from the next-state counter values, so they have zero skew against pix_x/pix_y (same clk edge).
- hsync=0 iff H_DISPLAY+H_FRONT <= pix_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
- vsync=0 iff V_DISPLAY+V_FRONT <= pix_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- video_on=1 iff pix_x < H_DISPLAY and pix_y < V_DISPLAY, and en=1.
- frame_end is combinational: p_tick & (pix_x==H_TOTAL-1) & (pix_y==V_TOTAL-1). It is high for one clk, the clk before the counters return to (0,0).
- en=0:
  - divider, pix_x and pix_y hold their values;
  - p_tick=0, frame_end=0;
  - video_on=0, hsync=1, vsync=1 from the next clk.
- en 0->1: counting resumes from the held values; syncs and video_on are re-decoded on the first clk.
- reset mid-line or mid-frame: all state returns to reset values on the next edge. The next frame begins at (0,0), with no partial sync pulse retained.
- reset has priority over en.
- Counters never exceed TOTAL-1; there are no illegal states.

Test Plan:
- Reset, then en=1 for 20 clks -> p_tick high on clks 4, 8, 12, 16, 20; pix_x=5 after clk 20; video_on=1 from clk 1; hsync=vsync=1.
- Run one line (3200 clks) -> hsync low for exactly 96 ticks (384 clks) starting at pix_x=656; video_on low from pix_x=640; pix_x wraps 799->0 while pix_y goes 0->1 on the same tick.
- Run a full frame -> vsync low for exactly 2 lines (pix_y=490..491, 6400 clks); frame_end pulses once after 420000 ticks (1,680,000 clks); video_on count = 307200 ticks.
- At pix_x=300, pix_y=100, drive en=0 for 50 clks -> pix_x/pix_y frozen at 300/100, p_tick=0, video_on=0; after en=1, p_tick resumes after the held divider phase and pix_x=301 at the next tick.
- Assert reset for 1 clk while pix_x=700, pix_y=491 (both syncs low) -> next clk: hsync=vsync=1, pix_x=pix_y=0, video_on=0; the next frame then runs full length.
- Sweep CLK_DIV=2 with the default timings -> line length 1600 clks, with all sync positions identical in tick units.
